// File: rtl/uart_pkg.sv
// uart_pkg -- definitions shared by the UART receiver and transmitter.
//   uart_state_e          : 2-bit frame FSM state (IDLE, START, DATA, STOP)
//   CLKS_PER_BIT_DEFAULT  : clk cycles per serial bit (10 MHz / 115200)
package uart_pkg;

    localparam int CLKS_PER_BIT_DEFAULT = 87;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if -- bundle of the receiver's serial input and byte hand-off signals.
//   rx_serial    : serial line, idle high
//   rx_next      : consumer acknowledge of the held byte
//   rx_dv        : held byte valid
//   rx_byte      : held byte
//   rx_overrun   : sticky overrun flag
//   rx_frame_err : one-cycle bad-stop-bit pulse
// master = line driver / byte consumer, slave = receiver.
interface uart_rx_if;
    logic       rx_serial;
    logic       rx_next;
    logic       rx_dv;
    logic [7:0] rx_byte;
    logic       rx_overrun;
    logic       rx_frame_err;

    modport master (
        output rx_serial,
        output rx_next,
        input  rx_dv,
        input  rx_byte,
        input  rx_overrun,
        input  rx_frame_err
    );

    modport slave (
        input  rx_serial,
        input  rx_next,
        output rx_dv,
        output rx_byte,
        output rx_overrun,
        output rx_frame_err
    );
endinterface

// File: rtl/uart_sync.sv
// uart_sync -- 2-flop synchronizer for one asynchronous bit.
//   clk, rst_n : clock, synchronous active-low reset
//   d          : asynchronous input
//   q          : synchronized output (RESET_VAL while in reset)
module uart_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;
endmodule

// File: rtl/uart_rx.sv
// uart_rx -- 8N1 UART receiver with a single-byte hold register.
//   clk, rst_n    : clock, synchronous active-low reset
//   i_Rx_Serial   : asynchronous serial line, idle high
//   i_Rx_Next     : acknowledge; releases the held byte while o_Rx_DV is high
//   o_Rx_DV       : held byte valid, stays high until acknowledged
//   o_Rx_Byte     : held byte, stable while o_Rx_DV is high
//   o_Rx_Overrun  : sticky, a completed byte was dropped; cleared by acknowledge
//   o_Rx_FrameErr : one-cycle pulse when a stop bit samples low
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_Rx_Serial,
    input  logic       i_Rx_Next,
    output logic       o_Rx_DV,
    output logic [7:0] o_Rx_Byte,
    output logic       o_Rx_Overrun,
    output logic       o_Rx_FrameErr
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    // Start bit is re-checked near its middle so later samples land mid-bit.
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);

    logic rx_sync;

    uart_sync #(.RESET_VAL(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (i_Rx_Serial),
        .q     (rx_sync)
    );

    uart_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             dv_q, dv_d;
    logic [7:0]       byte_q, byte_d;
    logic             ovr_q, ovr_d;
    logic             ferr_q, ferr_d;
    logic             deliver;
    logic             ack;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        dv_d    = dv_q;
        byte_d  = byte_q;
        ovr_d   = ovr_q;
        ferr_d  = 1'b0;
        deliver = 1'b0;
        ack     = dv_q & i_Rx_Next;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (!rx_sync) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    state_d = rx_sync ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_sync;
                    if (idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                    if (rx_sync) begin
                        deliver = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Hold register: an acknowledge in the delivery cycle frees the slot
        // for the new byte; otherwise a byte arriving on a full slot is lost.
        if (deliver) begin
            if (dv_q && !ack) begin
                ovr_d = 1'b1;
            end else begin
                byte_d = shift_q;
                dv_d   = 1'b1;
                if (ack) begin
                    ovr_d = 1'b0;
                end
            end
        end else if (ack) begin
            dv_d  = 1'b0;
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            dv_q    <= 1'b0;
            byte_q  <= '0;
            ovr_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            dv_q    <= dv_d;
            byte_q  <= byte_d;
            ovr_q   <= ovr_d;
            ferr_q  <= ferr_d;
        end
    end

    assign o_Rx_DV       = dv_q;
    assign o_Rx_Byte     = byte_q;
    assign o_Rx_Overrun  = ovr_q;
    assign o_Rx_FrameErr = ferr_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx -- directed self-checking bench for uart_rx at CLKS_PER_BIT = 4.
module tb_uart_rx;
    localparam int CPB = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   fe_cnt = 0;
    int   fe_run = 0;
    int   fe_max = 0;

    uart_rx_if rx_if ();

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_Rx_Serial   (rx_if.rx_serial),
        .i_Rx_Next     (rx_if.rx_next),
        .o_Rx_DV       (rx_if.rx_dv),
        .o_Rx_Byte     (rx_if.rx_byte),
        .o_Rx_Overrun  (rx_if.rx_overrun),
        .o_Rx_FrameErr (rx_if.rx_frame_err)
    );

    always #5 clk = ~clk;

    // Frame-error pulse monitor: total high cycles and longest run.
    always @(negedge clk) begin
        if (rx_if.rx_frame_err === 1'b1) begin
            fe_cnt = fe_cnt + 1;
            fe_run = fe_run + 1;
            if (fe_run > fe_max) fe_max = fe_run;
        end else begin
            fe_run = 0;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One 8N1 frame; ack_at_stop raises i_Rx_Next for the single cycle in
    // which the byte is delivered (stop bit sampled mid-bit).
    task automatic send_byte(input logic [7:0] b, input logic stop, input logic ack_at_stop);
        rx_if.rx_serial = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx_if.rx_serial = b[i];
            tick(CPB);
        end
        rx_if.rx_serial = stop;
        tick(CPB);
        rx_if.rx_serial = 1'b1;
        if (ack_at_stop) rx_if.rx_next = 1'b1;
        tick(1);
        rx_if.rx_next = 1'b0;
        tick(5);
        $display("tb: sent 0x%02h stop=%0b ack_at_stop=%0b -> dv=%0b byte=0x%02h ovr=%0b",
                 b, stop, ack_at_stop, rx_if.rx_dv, rx_if.rx_byte, rx_if.rx_overrun);
    endtask

    task automatic pulse_ack();
        rx_if.rx_next = 1'b1;
        tick(1);
        rx_if.rx_next = 1'b0;
        $display("tb: ack pulse");
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(3);
        @(negedge clk);
        checks++; if (rx_if.rx_dv !== 1'b0) begin errors++; $display("FAIL reset_dv got %0b want 0", rx_if.rx_dv); end
        checks++; if (rx_if.rx_byte !== 8'h00) begin errors++; $display("FAIL reset_byte got 0x%02h want 0x00", rx_if.rx_byte); end
        checks++; if (rx_if.rx_overrun !== 1'b0) begin errors++; $display("FAIL reset_ovr got %0b want 0", rx_if.rx_overrun); end
        checks++; if (rx_if.rx_frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr got %0b want 0", rx_if.rx_frame_err); end
        rst_n = 1'b1;
        tick(4);
        $display("tb: reset released");
    endtask

    task automatic test_hold_ack();
        send_byte(8'hA5, 1'b1, 1'b0);
        @(negedge clk);
        checks++; if (rx_if.rx_dv !== 1'b1) begin errors++; $display("FAIL a5_dv got %0b want 1", rx_if.rx_dv); end
        checks++; if (rx_if.rx_byte !== 8'hA5) begin errors++; $display("FAIL a5_byte got 0x%02h want 0xa5", rx_if.rx_byte); end
        tick(40);
        @(negedge clk);
        checks++; if (rx_if.rx_dv !== 1'b1 || rx_if.rx_byte !== 8'hA5) begin errors++; $display("FAIL a5_hold got dv=%0b byte=0x%02h want dv=1 byte=0xa5", rx_if.rx_dv, rx_if.rx_byte); end
        pulse_ack();
        @(negedge clk);
        checks++; if (rx_if.rx_dv !== 1'b0) begin errors++; $display("FAIL a5_ack_dv got %0b want 0", rx_if.rx_dv); end
        checks++; if (rx_if.rx_byte !== 8'hA5) begin errors++; $display("FAIL a5_ack_byte got 0x%02h want 0xa5", rx_if.rx_byte); end
        // Acknowledge with nothing held must be ignored.
        rx_if.rx_next = 1'b1;
        tick(3);
        rx_if.rx_next = 1'b0;
        @(negedge clk);
        checks++; if (rx_if.rx_dv !== 1'b0 || rx_if.rx_overrun !== 1'b0) begin errors++; $display("FAIL idle_ack got dv=%0b ovr=%0b want 0 0", rx_if.rx_dv, rx_if.rx_overrun); end
    endtask

    task automatic test_overrun();
        send_byte(8'h3C, 1'b1, 1'b0);
        @(negedge clk);
        checks++; if (rx_if.rx_dv !== 1'b1 || rx_if.rx_byte !== 8'h3C) begin errors++; $display("FAIL 3c_dv got dv=%0b byte=0x%02h want 1 0x3c", rx_if.rx_dv, rx_if.rx_byte); end
        send_byte(8'h7E, 1'b1, 1'b0);
        @(negedge clk);
        checks++; if (rx_if.rx_byte !== 8'h3C) begin errors++; $display("FAIL ovr_byte got 0x%02h want 0x3c", rx_if.rx_byte); end
        checks++; if (rx_if.rx_overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag got %0b want 1", rx_if.rx_overrun); end
        checks++; if (rx_if.rx_dv !== 1'b1) begin errors++; $display("FAIL ovr_dv got %0b want 1", rx_if.rx_dv); end
        pulse_ack();
        @(negedge clk);
        checks++; if (rx_if.rx_dv !== 1'b0 || rx_if.rx_overrun !== 1'b0) begin errors++; $display("FAIL ovr_ack got dv=%0b ovr=%0b want 0 0", rx_if.rx_dv, rx_if.rx_overrun); end
    endtask

    task automatic test_back_to_back();
        send_byte(8'h11, 1'b1, 1'b0);
        @(negedge clk);
        checks++; if (rx_if.rx_dv !== 1'b1 || rx_if.rx_byte !== 8'h11) begin errors++; $display("FAIL 11_held got dv=%0b byte=0x%02h want 1 0x11", rx_if.rx_dv, rx_if.rx_byte); end
        send_byte(8'h22, 1'b1, 1'b1);
        @(negedge clk);
        checks++; if (rx_if.rx_byte !== 8'h22) begin errors++; $display("FAIL coin_byte got 0x%02h want 0x22", rx_if.rx_byte); end
        checks++; if (rx_if.rx_dv !== 1'b1) begin errors++; $display("FAIL coin_dv got %0b want 1", rx_if.rx_dv); end
        checks++; if (rx_if.rx_overrun !== 1'b0) begin errors++; $display("FAIL coin_ovr got %0b want 0", rx_if.rx_overrun); end
        pulse_ack();
    endtask

    task automatic test_frame_err();
        int fe_before;
        fe_before = fe_cnt;
        fe_max    = 0;
        send_byte(8'h55, 1'b0, 1'b0);
        tick(4);
        @(negedge clk);
        checks++; if (fe_cnt - fe_before !== 1) begin errors++; $display("FAIL ferr_count got %0d want 1", fe_cnt - fe_before); end
        checks++; if (fe_max !== 1) begin errors++; $display("FAIL ferr_width got %0d want 1", fe_max); end
        checks++; if (rx_if.rx_dv !== 1'b0) begin errors++; $display("FAIL ferr_dv got %0b want 0", rx_if.rx_dv); end
        // One-clock low glitch must not start a frame.
        fe_before = fe_cnt;
        rx_if.rx_serial = 1'b0;
        tick(1);
        rx_if.rx_serial = 1'b1;
        tick(60);
        $display("tb: 1-clk glitch on line");
        @(negedge clk);
        checks++; if (rx_if.rx_dv !== 1'b0 || fe_cnt !== fe_before) begin errors++; $display("FAIL glitch got dv=%0b ferr_pulses=%0d want 0 0", rx_if.rx_dv, fe_cnt - fe_before); end
        send_byte(8'h5A, 1'b1, 1'b0);
        @(negedge clk);
        checks++; if (rx_if.rx_dv !== 1'b1 || rx_if.rx_byte !== 8'h5A) begin errors++; $display("FAIL post_glitch got dv=%0b byte=0x%02h want 1 0x5a", rx_if.rx_dv, rx_if.rx_byte); end
    endtask

    task automatic test_reset_mid_frame();
        int fe_before;
        fe_before = fe_cnt;
        rx_if.rx_serial = 1'b0;
        tick(CPB);
        rx_if.rx_serial = 1'b1;
        tick(4 * CPB + 2);
        rst_n = 1'b0;
        tick(2);
        @(negedge clk);
        checks++; if (rx_if.rx_dv !== 1'b0 || rx_if.rx_byte !== 8'h00) begin errors++; $display("FAIL midrst got dv=%0b byte=0x%02h want 0 0x00", rx_if.rx_dv, rx_if.rx_byte); end
        rst_n = 1'b1;
        tick(6 * CPB);
        $display("tb: reset during bit 4 of 0xff");
        send_byte(8'h81, 1'b1, 1'b0);
        @(negedge clk);
        checks++; if (rx_if.rx_dv !== 1'b1 || rx_if.rx_byte !== 8'h81) begin errors++; $display("FAIL after_rst got dv=%0b byte=0x%02h want 1 0x81", rx_if.rx_dv, rx_if.rx_byte); end
        checks++; if (rx_if.rx_overrun !== 1'b0 || fe_cnt !== fe_before) begin errors++; $display("FAIL after_rst_flags got ovr=%0b ferr_pulses=%0d want 0 0", rx_if.rx_overrun, fe_cnt - fe_before); end
    endtask

    initial begin
        rx_if.rx_serial = 1'b1;
        rx_if.rx_next   = 1'b0;
        test_reset();
        test_hold_ack();
        test_overrun();
        test_back_to_back();
        test_frame_err();
        pulse_ack();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter: CLKS_PER_BIT, default 87, meaning clk cycles per serial bit (10 MHz / 115200); legal range 4..65535.
REQ-002 SHALL have port: clk  input  1  single system clock; all logic on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port: i_Rx_Serial  input  1  asynchronous serial line, idle high.
REQ-005 SHALL have port: i_Rx_Next  input  1  consumer acknowledge; high while o_Rx_DV high releases the held byte.
REQ-006 SHALL have port: o_Rx_DV  output  1  held byte valid; stays high until acknowledged.
REQ-007 SHALL have port: o_Rx_Byte  output  8  held byte, stable while o_Rx_DV high.
REQ-008 SHALL have port: o_Rx_Overrun  output  1  sticky, set when a completed byte is dropped.
REQ-009 SHALL have port: o_Rx_FrameErr  output  1  one-cycle pulse on a bad stop bit.

Function
REQ-010 SHALL pass i_Rx_Serial through a 2-flop synchronizer before any use; synchronizer resets to 1.
REQ-011 SHALL implement FSM states IDLE, START, DATA, STOP; frame = 1 start, 8 data LSB-first, 1 stop, no parity.
REQ-012 IDLE: synced line 0 -> START with bit counter cleared; else stay.
REQ-013 START: after (CLKS_PER_BIT-1)/2 cycles resample; 0 -> DATA, counter cleared; 1 -> IDLE (glitch rejected, no outputs change).
REQ-014 DATA: every CLKS_PER_BIT cycles sample one bit into shift register bit[index]; after index 7 -> STOP.
REQ-015 STOP: after CLKS_PER_BIT cycles sample; 1 -> deliver byte (REQ-016); 0 -> discard byte, pulse o_Rx_FrameErr for 1 cycle; both -> IDLE same edge.
REQ-016 Delivery: o_Rx_Byte loaded and o_Rx_DV set on the clock edge after the stop-bit sample.
REQ-017 Acknowledge: o_Rx_DV high and i_Rx_Next high at a rising edge -> o_Rx_DV low next cycle; o_Rx_Byte keeps last value.
REQ-018 i_Rx_Next high while o_Rx_DV low SHALL have no effect.
REQ-019 Delivery while o_Rx_DV high and no acknowledge in the same cycle: new byte dropped, o_Rx_Byte unchanged, o_Rx_Overrun set.
REQ-020 Delivery and acknowledge in the same cycle: new byte loaded, o_Rx_DV stays high, no overrun.
REQ-021 o_Rx_Overrun SHALL clear on the next acknowledge (REQ-017) unless a new overrun occurs in that same cycle.
REQ-022 Baud counter width SHALL be $clog2(CLKS_PER_BIT); counter resets to 0 on each state entry, never wraps mid-bit.
REQ-023 Receiver SHALL keep sampling new frames while a byte is held; reception is never stalled by the consumer.

Reset
REQ-024 rst_n low at a rising edge: state IDLE, counters 0, shift register 0, o_Rx_DV 0, o_Rx_Byte 0x00, o_Rx_Overrun 0, o_Rx_FrameErr 0, synchronizer 1.
REQ-025 Reset mid-frame SHALL abandon the frame; after release, reception resumes at the next falling edge of the line.

Structure
REQ-026 Package uart_pkg SHALL hold the FSM state enum (2-bit) and CLKS_PER_BIT default constant, shared with the transmitter.
REQ-027 The 2-flop synchronizer SHALL be sub-module uart_sync (1-bit, reset value parameterized); everything else lives in uart_rx.

Verification (CLKS_PER_BIT=4)
REQ-028 Send 0xA5, i_Rx_Next=0 -> o_Rx_DV=1, o_Rx_Byte=0xA5, held indefinitely; pulse i_Rx_Next 1 cycle -> o_Rx_DV=0 next cycle.
REQ-029 Send 0x3C, then 0x7E with no acknowledge -> o_Rx_Byte stays 0x3C, o_Rx_Overrun=1; acknowledge -> both flags 0.
REQ-030 Send 0x11 and hold i_Rx_Next=1 so the 0x22 delivery coincides with acknowledge -> o_Rx_Byte=0x22, o_Rx_DV stays 1, o_Rx_Overrun=0.
REQ-031 Send 0x55 with stop bit 0 -> o_Rx_FrameErr single-cycle pulse, o_Rx_DV stays 0; line low 1 clk only -> no START progression to DATA.
REQ-032 Assert rst_n=0 during bit 4 of 0xFF, release, send 0x81 -> o_Rx_Byte=0x81, no error or overrun.
